// File: rtl/avalon_st_2_avalon_st_video.sv
// Unpacks a 32-bit byte-packed Avalon-ST stream into 24-bit Avalon-ST Video pixels,
// prefixing each packet with an optional control packet and a type-0 video header.
module avalon_st_2_avalon_st_video #(
  parameter bit          EMIT_CTRL    = 1'b1,
  parameter logic [15:0] FRAME_WIDTH  = 16'd480,
  parameter logic [15:0] FRAME_HEIGHT = 16'd800,
  parameter logic [3:0]  INTERLACE    = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_avl_st_data,
  input  logic        in_avl_st_valid,
  input  logic        in_avl_st_startofpacket,
  input  logic        in_avl_st_endofpacket,
  output logic        in_avl_st_ready,
  output logic [23:0] out_avl_st_data,
  output logic        out_avl_st_valid,
  output logic        out_avl_st_startofpacket,
  output logic        out_avl_st_endofpacket,
  input  logic        out_avl_st_ready,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE, CTRL_HDR, CTRL_D0, CTRL_D1, CTRL_D2, VID_HDR, PIXELS
  } state_t;

  localparam logic [23:0] CTRL_HDR_BEAT = 24'h00000F;
  localparam logic [23:0] CTRL_D0_BEAT  = {4'h0, FRAME_WIDTH[7:4], 4'h0, FRAME_WIDTH[11:8],
                                           4'h0, FRAME_WIDTH[15:12]};
  localparam logic [23:0] CTRL_D1_BEAT  = {4'h0, FRAME_HEIGHT[11:8], 4'h0, FRAME_HEIGHT[15:12],
                                           4'h0, FRAME_WIDTH[3:0]};
  localparam logic [23:0] CTRL_D2_BEAT  = {4'h0, INTERLACE, 4'h0, FRAME_HEIGHT[3:0],
                                           4'h0, FRAME_HEIGHT[7:4]};

  state_t      state;
  logic [63:0] shift_reg;
  logic [2:0]  count;
  logic        eop_seen;

  logic        can_load, accept, word_in, emit_pix, eop_eff, last_pix;
  logic [3:0]  avail, remain;
  logic [63:0] merged;

  assign can_load = !out_avl_st_valid || out_avl_st_ready;

  // IDLE only takes a word when the output stage could take its header in the same cycle.
  always_comb begin
    in_avl_st_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_avl_st_ready = can_load;
        PIXELS:  in_avl_st_ready = (count <= 3'd2) && !eop_seen;
        default: in_avl_st_ready = 1'b0;
      endcase
    end
  end

  // The incoming word is merged combinationally so a pixel can use it in the accept cycle.
  assign accept   = in_avl_st_valid && in_avl_st_ready;
  assign word_in  = accept && (state == PIXELS);
  assign merged   = word_in ? (shift_reg | ({32'd0, in_avl_st_data} << {count, 3'b000}))
                            : shift_reg;
  assign avail    = {1'b0, count} + (word_in ? 4'd4 : 4'd0);
  assign remain   = avail - 4'd3;
  assign emit_pix = ((state == VID_HDR) || (state == PIXELS)) && can_load && (avail >= 4'd3);
  assign eop_eff  = eop_seen || (word_in && in_avl_st_endofpacket);
  assign last_pix = eop_eff && (remain < 4'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      shift_reg                <= '0;
      count                    <= '0;
      eop_seen                 <= 1'b0;
      out_avl_st_valid         <= 1'b0;
      out_avl_st_data          <= '0;
      out_avl_st_startofpacket <= 1'b0;
      out_avl_st_endofpacket   <= 1'b0;
      frame_err                <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (can_load) begin
        out_avl_st_valid         <= 1'b0;
        out_avl_st_startofpacket <= 1'b0;
        out_avl_st_endofpacket   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept && in_avl_st_startofpacket) begin
            shift_reg                <= {32'd0, in_avl_st_data};
            count                    <= 3'd4;
            eop_seen                 <= in_avl_st_endofpacket;
            out_avl_st_valid         <= 1'b1;
            out_avl_st_startofpacket <= 1'b1;
            out_avl_st_data          <= EMIT_CTRL ? CTRL_HDR_BEAT : 24'h000000;
            state                    <= EMIT_CTRL ? CTRL_HDR : VID_HDR;
          end
        end
        CTRL_HDR: if (can_load) begin
          out_avl_st_valid <= 1'b1;
          out_avl_st_data  <= CTRL_D0_BEAT;
          state            <= CTRL_D0;
        end
        CTRL_D0: if (can_load) begin
          out_avl_st_valid <= 1'b1;
          out_avl_st_data  <= CTRL_D1_BEAT;
          state            <= CTRL_D1;
        end
        CTRL_D1: if (can_load) begin
          out_avl_st_valid       <= 1'b1;
          out_avl_st_endofpacket <= 1'b1;
          out_avl_st_data        <= CTRL_D2_BEAT;
          state                  <= CTRL_D2;
        end
        CTRL_D2: if (can_load) begin
          out_avl_st_valid         <= 1'b1;
          out_avl_st_startofpacket <= 1'b1;
          out_avl_st_data          <= 24'h000000;
          state                    <= VID_HDR;
        end
        default: begin
          // VID_HDR and PIXELS: one pixel per loaded beat, b0 lands in the top symbol.
          if (emit_pix) begin
            out_avl_st_valid       <= 1'b1;
            out_avl_st_data        <= {merged[7:0], merged[15:8], merged[23:16]};
            out_avl_st_endofpacket <= last_pix;
            if (last_pix) begin
              shift_reg <= '0;
              count     <= '0;
              eop_seen  <= 1'b0;
              frame_err <= (remain != 4'd0);
              state     <= IDLE;
            end else begin
              shift_reg <= merged >> 24;
              count     <= remain[2:0];
              eop_seen  <= eop_eff;
              state     <= PIXELS;
            end
          end else if (word_in) begin
            shift_reg <= merged;
            count     <= avail[2:0];
            eop_seen  <= eop_eff;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_2_avalon_st_video.sv
// Scoreboard bench: instance 0 has no control packet, instance 1 emits one (480x800).
module tb_avalon_st_2_avalon_st_video;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][31:0] in_data = '0;
  logic [1:0]       in_valid = '0;
  logic [1:0]       in_sop = '0;
  logic [1:0]       in_eop = '0;
  logic [1:0]       in_ready;
  logic [1:0][23:0] out_data;
  logic [1:0]       out_valid, out_sop, out_eop, frame_err;
  logic [1:0]       out_ready = 2'b11;
  logic [1:0]       stall_en = '0;

  logic [25:0] exp_q0[$];
  logic [25:0] exp_q1[$];
  int assert_count = 0;
  int fail_count = 0;
  int err_pulses[2] = '{0, 0};

  always #5 clk = ~clk;

  avalon_st_2_avalon_st_video #(.EMIT_CTRL(1'b0)) dut_raw (
    .clk(clk), .rst(rst),
    .in_avl_st_data(in_data[0]), .in_avl_st_valid(in_valid[0]),
    .in_avl_st_startofpacket(in_sop[0]), .in_avl_st_endofpacket(in_eop[0]),
    .in_avl_st_ready(in_ready[0]),
    .out_avl_st_data(out_data[0]), .out_avl_st_valid(out_valid[0]),
    .out_avl_st_startofpacket(out_sop[0]), .out_avl_st_endofpacket(out_eop[0]),
    .out_avl_st_ready(out_ready[0]), .frame_err(frame_err[0])
  );

  avalon_st_2_avalon_st_video #(.EMIT_CTRL(1'b1)) dut_ctrl (
    .clk(clk), .rst(rst),
    .in_avl_st_data(in_data[1]), .in_avl_st_valid(in_valid[1]),
    .in_avl_st_startofpacket(in_sop[1]), .in_avl_st_endofpacket(in_eop[1]),
    .in_avl_st_ready(in_ready[1]),
    .out_avl_st_data(out_data[1]), .out_avl_st_valid(out_valid[1]),
    .out_avl_st_startofpacket(out_sop[1]), .out_avl_st_endofpacket(out_eop[1]),
    .out_avl_st_ready(out_ready[1]), .frame_err(frame_err[1])
  );

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    assert_count++;
    if (act !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int qsize(int idx);
    return (idx == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic pushBeat(int idx, bit sop, bit eop, logic [23:0] d);
    if (idx == 0) exp_q0.push_back({sop, eop, d});
    else          exp_q1.push_back({sop, eop, d});
  endtask

  // Consumer back-pressure changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      out_ready[i] = stall_en[i] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Every valid beat, stalled or not, must equal the head of its queue; pop on handshake.
  always @(negedge clk) begin
    logic [25:0] act;
    logic [25:0] expv;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (frame_err[i]) err_pulses[i]++;
        if (out_valid[i]) begin
          act = {out_sop[i], out_eop[i], out_data[i]};
          if (qsize(i) == 0) begin
            checkOutput(i == 0 ? "unexpected_beat_raw" : "unexpected_beat_ctrl", {6'd0, act}, 32'hFFFF_FFFF);
          end else begin
            expv = (i == 0) ? exp_q0[0] : exp_q1[0];
            checkOutput(i == 0 ? "beat_raw" : "beat_ctrl", {6'd0, act}, {6'd0, expv});
            if (out_ready[i]) begin
              if (i == 0) void'(exp_q0.pop_front());
              else        void'(exp_q1.pop_front());
            end
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic applyStimulus(int idx, logic [31:0] d, bit sop, bit eop);
    bit done = 1'b0;
    int waited = 0;
    in_data[idx]  = d;
    in_sop[idx]   = sop;
    in_eop[idx]   = eop;
    in_valid[idx] = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready[idx];
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 300) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid[idx] = 1'b0;
    in_sop[idx]   = 1'b0;
    in_eop[idx]   = 1'b0;
  endtask

  task automatic waitDrain(int idx);
    int n = 0;
    while (qsize(idx) != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", qsize(idx), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_in_ready", {31'd0, in_ready[i]}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid[i]}, 32'd0);
      checkOutput("rst_out_data", {8'd0, out_data[i]}, 32'd0);
      checkOutput("rst_out_sop", {31'd0, out_sop[i]}, 32'd0);
      checkOutput("rst_out_eop", {31'd0, out_eop[i]}, 32'd0);
      checkOutput("rst_frame_err", {31'd0, frame_err[i]}, 32'd0);
    end
  endtask

  task automatic sendShortPacket(int idx);
    applyStimulus(idx, 32'h44332211, 1'b1, 1'b0);
    applyStimulus(idx, 32'h88776655, 1'b0, 1'b0);
    applyStimulus(idx, 32'hCCBBAA99, 1'b0, 1'b1);
  endtask

  task automatic expectShortPixels(int idx);
    pushBeat(idx, 1'b0, 1'b0, 24'h112233);
    pushBeat(idx, 1'b0, 1'b0, 24'h445566);
    pushBeat(idx, 1'b0, 1'b0, 24'h778899);
    pushBeat(idx, 1'b0, 1'b1, 24'hAABBCC);
  endtask

  // Byte k of the long packet is k[7:0]; pixel p = {b(3p), b(3p+1), b(3p+2)}.
  task automatic runLongPacket(bit stall);
    int base;
    base = err_pulses[0];
    stall_en[0] = stall;
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    for (int p = 0; p < 480; p++)
      pushBeat(0, 1'b0, p == 479, {8'(3*p), 8'(3*p+1), 8'(3*p+2)});
    for (int w = 0; w < 360; w++)
      applyStimulus(0, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, w == 0, w == 359);
    waitDrain(0);
    stall_en[0] = 1'b0;
    checkOutput("long_frame_err", err_pulses[0] - base, 32'd0);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] short packet, no control packet");
    base = err_pulses[0];
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    expectShortPixels(0);
    sendShortPacket(0);
    waitDrain(0);
    checkOutput("short_frame_err", err_pulses[0] - base, 32'd0);

    $display("[TB] short packet with control packet");
    base = err_pulses[1];
    pushBeat(1, 1'b1, 1'b0, 24'h00000F);
    pushBeat(1, 1'b0, 1'b0, 24'h0E0100);
    pushBeat(1, 1'b0, 1'b0, 24'h030000);
    pushBeat(1, 1'b0, 1'b1, 24'h000002);
    pushBeat(1, 1'b1, 1'b0, 24'h000000);
    expectShortPixels(1);
    sendShortPacket(1);
    waitDrain(1);
    checkOutput("ctrl_frame_err", err_pulses[1] - base, 32'd0);

    $display("[TB] single SOP+EOP word");
    base = err_pulses[0];
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    pushBeat(0, 1'b0, 1'b1, 24'hAABBCC);
    applyStimulus(0, 32'hDDCCBBAA, 1'b1, 1'b1);
    waitDrain(0);
    checkOutput("partial_frame_err", err_pulses[0] - base, 32'd1);

    $display("[TB] garbage words in IDLE then packet");
    applyStimulus(0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(0, 32'h01020304, 1'b0, 1'b1);
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    expectShortPixels(0);
    sendShortPacket(0);
    waitDrain(0);

    $display("[TB] 480-pixel packet without and with back-pressure");
    runLongPacket(1'b0);
    runLongPacket(1'b1);

    $display("[TB] reset after two pixels");
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    pushBeat(0, 1'b0, 1'b0, 24'h112233);
    pushBeat(0, 1'b0, 1'b0, 24'h445566);
    applyStimulus(0, 32'h44332211, 1'b1, 1'b0);
    applyStimulus(0, 32'h88776655, 1'b0, 1'b0);
    waitDrain(0);
    rst = 1'b1;
    @(posedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    checkOutput("post_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    pushBeat(0, 1'b1, 1'b0, 24'h000000);
    expectShortPixels(0);
    sendShortPacket(0);
    waitDrain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
